// File: rtl/spi_master.sv
// rtl/spi_master.sv - bit-per-clk SPI master for the SPI-to-RAM link (write/read address and data frames)
module spi_master #(
    parameter int RD_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    input  logic       MISO,
    output logic       SS_n,
    output logic       MOSI,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_SHIFT,
        S_WAIT,
        S_RECV,
        S_END
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  frame_q, frame_d;
    logic [7:0]  shreg_q, shreg_d;

    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rv_q, rv_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        is_read;
    assign is_read = (frame_q[9:8] == 2'b11);

    // State, bit counter, latched frame and receive shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            frame_q <= 10'd0;
            shreg_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            shreg_q <= shreg_d;
        end
    end

    // Next state: frame sequencing, counter restarts at 0 on every state entry
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CMD;
                    frame_d = {cmd, wdata};
                end
            end
            S_CMD:   state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == 4'd9) state_d = is_read ? S_WAIT : S_END;
            S_WAIT:  if (cnt_q == WAIT_LAST) state_d = S_RECV;
            S_RECV: begin
                shreg_d[cnt_q[2:0]] = MISO;
                if (cnt_q == 4'd7) state_d = S_END;
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q || state_q == S_IDLE) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Outputs decoded from the upcoming state so the registered pins line up with it
    always_comb begin
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
        done_d  = 1'b0;
        rv_d    = 1'b0;
        rdata_d = rdata_q;
        case (state_d)
            S_CMD: begin
                ss_n_d = 1'b0;
                mosi_d = frame_d[9];
            end
            S_SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = frame_d[cnt_d];
            end
            S_WAIT, S_RECV: ss_n_d = 1'b0;
            S_END: begin
                done_d = 1'b1;
                if (is_read) begin
                    rv_d    = 1'b1;
                    rdata_d = shreg_d;
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset drops SS_n high without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
        end
    end

    assign SS_n        = ss_n_q;
    assign MOSI        = mosi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata_valid = rv_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master with a frame-level reference model
module tb_spi_master;

    localparam int RD_WAIT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       MISO;
    logic       SS_n;
    logic       MOSI;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rdata_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_rdata;
    logic [7:0] mem [256];
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;

    spi_master #(.RD_WAIT(RD_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd        (cmd),
        .wdata      (wdata),
        .MISO       (MISO),
        .SS_n       (SS_n),
        .MOSI       (MOSI),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .rdata_valid(rdata_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One frame from acceptance through the following IDLE cycle, checked cycle by cycle.
    // Entered and left at #1 after an edge with the DUT idle.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] w,
                             input bit keep_start, input bit poke, input bit use_mem);
        logic [9:0] f;
        logic [7:0] rx;
        logic [4:0] exp_ctl;
        bit         rd;
        int         len;
        int         j;
        f   = {c, w};
        rd  = (c == 2'b11);
        len = rd ? 20 + RD_WAIT : 12;
        rx  = 8'h00;
        cmd   = c;
        wdata = w;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        cmd   = 2'($urandom);
        wdata = 8'($urandom);
        for (int k = 1; k <= len + 1; k++) begin
            j = k - 12 - RD_WAIT;
            if (use_mem && rd && j >= 0 && j < 8) MISO = mem[rd_addr][j];
            else MISO = 1'($urandom);
            if (rd && j >= 0 && j < 8) rx[j] = MISO;
            if (poke && k == 5) begin
                start = 1'b1;
                cmd   = 2'b11;
            end
            if (poke && k == 6) start = 1'b0;
            // {SS_n, MOSI, busy, done, rdata_valid}
            if (k == len + 1)   exp_ctl = 5'b10000;
            else if (k == len)  exp_ctl = {3'b101, 1'b1, rd};
            else if (k == 1)    exp_ctl = {1'b0, c[1], 1'b1, 2'b00};
            else if (k <= 11)   exp_ctl = {1'b0, f[k-2], 1'b1, 2'b00};
            else                exp_ctl = 5'b00100;
            if (k == len && rd) exp_rdata = rx;
            check($sformatf("ctl c=%0d k=%0d", c, k), 32'(exp_ctl) ^ 32'(exp_ctl) | 32'({SS_n, MOSI, busy, done, rdata_valid}), 32'(exp_ctl));
            check($sformatf("rdata c=%0d k=%0d", c, k), 32'(rdata), 32'(exp_rdata));
            if (k <= len) begin
                @(posedge clk);
                #1;
            end
        end
        case (c)
            2'b00: wr_addr = w;
            2'b01: mem[wr_addr] = w;
            2'b10: rd_addr = w;
            default: ;
        endcase
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cmd   = 2'b00;
        wdata = 8'h00;
        MISO  = 1'b0;
        exp_rdata = 8'h00;
        wr_addr = 8'h00;
        rd_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset ctl", 32'({SS_n, MOSI, busy, done, rdata_valid}), 32'h10);
        check("reset rdata", 32'(rdata), 32'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle ctl", 32'({SS_n, MOSI, busy, done, rdata_valid}), 32'h10);

        // Write-address 0xA5
        run_frame(2'b00, 8'hA5, 1'b0, 1'b0, 1'b0);

        // Read-data returning 0x96 via the slave memory
        run_frame(2'b00, 8'h40, 1'b0, 1'b0, 1'b0);
        run_frame(2'b01, 8'h96, 1'b0, 1'b0, 1'b0);
        run_frame(2'b10, 8'h40, 1'b0, 1'b0, 1'b0);
        run_frame(2'b11, 8'h5A, 1'b0, 1'b0, 1'b1);
        check("read 96", 32'(rdata), 32'h96);

        // start while busy is ignored
        run_frame(2'b00, 8'h3B, 1'b0, 1'b1, 1'b0);

        // back-to-back frames with start held high
        run_frame(2'b10, 8'h12, 1'b1, 1'b0, 1'b0);
        run_frame(2'b11, 8'hC3, 1'b0, 1'b0, 1'b0);

        // end-to-end write/read through the slave memory
        run_frame(2'b00, 8'h12, 1'b0, 1'b0, 1'b0);
        run_frame(2'b01, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_frame(2'b10, 8'h12, 1'b0, 1'b0, 1'b0);
        run_frame(2'b11, 8'h00, 1'b0, 1'b0, 1'b1);
        check("e2e rdata", 32'(rdata), 32'h3C);

        // reset mid-SHIFT of a write-data frame
        cmd   = 2'b01;
        wdata = 8'hE7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_rdata = 8'h00;
        check("midframe rst ctl", 32'({SS_n, MOSI, busy, done, rdata_valid}), 32'h10);
        check("midframe rst rdata", 32'(rdata), 32'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post rst idle", 32'({SS_n, MOSI, busy, done, rdata_valid}), 32'h10);
        run_frame(2'b01, 8'hE7, 1'b0, 1'b0, 1'b0);

        // randomized frames, random MISO, occasional back-to-back
        for (int n = 0; n < 24; n++) begin
            run_frame(2'($urandom), 8'($urandom), (n != 23) && ($urandom_range(0, 2) == 0),
                      1'b0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master that drives the SS_n/MOSI side of the team's SPI-to-RAM protocol and receives read data on MISO. It sits between a local control interface (start/cmd/wdata) and a `SPI_Slave` instance that fronts the data memory. All link signals are bit-per-`clk`, with no separate serial clock. This matches the slave, which samples MOSI on every rising edge of the shared `clk`.

## Interface
Parameters:
- RD_WAIT, default 3: number of idle cycles between the last frame bit and the first MISO sample of a read-data transfer (range 1–15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- cmd  input  2  command: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
- wdata  input  8  payload byte (address or data; ignored content for cmd 11 but still sent).
- MISO  input  1  serial data from slave.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to slave.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse at transfer end.
- rdata  output  8  byte received in the last read-data transfer.
- rdata_valid  output  1  one-cycle pulse, coincident with done, for cmd 11 only.

## Operation
- Reset values: SS_n=1, MOSI=0, busy=0, done=0, rdata=8'h00, rdata_valid=0, state=IDLE, bit counter=0.
- Reset behaviour: rst asserted at any time, including mid-frame, aborts immediately to the reset values. SS_n rises asynchronously. No partial rdata update.
- Frame: F[9:0] = {cmd, wdata}, latched on start acceptance. Later changes to cmd/wdata have no effect.
- States:
  - IDLE: SS_n=1, MOSI=0. start=1 → latch F, go to CMD.
  - CMD: SS_n=0, MOSI=cmd[1], the slave's command-check bit. Next state is SHIFT.
  - SHIFT: 10 cycles, SS_n=0, MOSI=F[i] for i=0..9, LSB first. After i=9, cmd=11 → WAIT; otherwise → END.
  - WAIT: RD_WAIT cycles, SS_n=0, MOSI=0. Next state is RECV.
  - RECV: 8 cycles, SS_n=0, MOSI=0. MISO sampled into shift register bit j=0..7, LSB first. Next state is END.
  - END: SS_n=1, MOSI=0, done=1. If cmd=11: rdata ← shift register, rdata_valid=1. Next state is IDLE.
- start while busy: ignored, not queued. start held high in IDLE begins back-to-back frames, each separated by the END cycle plus the IDLE cycle.
- MISO is ignored outside RECV. rdata holds its value until the next completed cmd-11 transfer.
- Bit counter: 4 bits, cleared on every state entry, and it never wraps within a state.

## Timing
- All outputs are registered. start sampled at edge T:
  - SS_n falls after edge T+1 (CMD).
  - F[0] is on MOSI in cycle T+2, F[9] in cycle T+11.
- Write / read-address (cmd 00/01/10):
  - END in cycle T+12, so done=1 and SS_n=1 there.
  - IDLE at T+13; busy low from T+13.
  - Frame length is 11 cycles with SS_n low.
- Read-data (cmd 11):
  - WAIT cycles T+12..T+11+RD_WAIT.
  - MISO bit j sampled at the end of cycle T+12+RD_WAIT+j.
  - END at T+20+RD_WAIT, with done=rdata_valid=1. With the default RD_WAIT=3 this is T+23.
- Minimum SS_n-high gap between frames: 2 cycles (END + IDLE).
- busy=1 from T+1 through the END cycle inclusive.

## Test plan
- Reset: assert rst mid-SHIFT of a cmd=01 frame → SS_n=1, MOSI=0, busy=0, done=0 in the same cycle. After release, the next start=1 produces a full, clean frame.
- Write-address: start, cmd=00, wdata=8'hA5 → MOSI sequence 0, then 1,0,1,0,0,1,0,1,0,0 on T+2..T+11. SS_n low T+1..T+11, done pulse at T+12, rdata_valid=0.
- Read-data, RD_WAIT=3: start cmd=11. Drive MISO bits 0,1,1,0,1,0,0,1 during T+15..T+22 → rdata=8'h96 and rdata_valid=done=1 at T+23. MISO toggling during WAIT does not alter rdata.
- start while busy: pulse start again at T+5 with cmd=11 → ignored. The frame completes as the original cmd=00, and exactly one done pulse is produced.
- Back-to-back: start held high with cmd=10 then 11 → second SS_n fall exactly 2 cycles after the first frame's END. Both frames are bit-exact.
- End-to-end: master + `SPI_Slave` + memory. Write address 8'h12, then data 8'h3C, then read address 8'h12, then read-data → rdata=8'h3C.
